instruction_decode_unit: RTL and testbench
==========================================

INSTRUCTION_DECODE_UNIT -- requirements
Module: instruction_decode_unit

Interface
REQ-001 Parameter: NOP_INSTR, 32'h00000013, encoding recorded in out_instr for bubbles and after reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 Instruction_Code  input  32  instruction word from the fetch stage.
REQ-005 in_valid  input  1  Instruction_Code is a valid instruction this cycle.
REQ-006 stall  input  1  hold all ID/EX outputs; input instruction is not consumed.
REQ-007 flush  input  1  replace the next ID/EX contents with a bubble.
REQ-008 wb_en  input  1  register-file write enable from writeback.
REQ-009 wb_addr  input  5  write destination register.
REQ-010 wb_data  input  32  write data.
REQ-011 out_valid  output  1  ID/EX register holds a real instruction.
REQ-012 out_instr  output  32  registered copy of the decoded instruction word.
REQ-013 opcode, funct3, funct7  output  7/3/7  registered instruction fields.
REQ-014 rd, rs1, rs2  output  5 each  registered register indices.
REQ-015 rs1_data, rs2_data  output  32 each  registered operand values.
REQ-016 imm  output  32  registered sign-extended immediate.
REQ-017 reg_write  output  1  the instruction writes a nonzero rd.
REQ-018 illegal  output  1  the opcode is not in the supported RV32I set.

Function
REQ-019 Register file: 32 x 32 bits; x0 reads as 0; writes to x0 are ignored.
REQ-020 Write timing: x[wb_addr] <= wb_data at posedge clock when wb_en=1 and wb_addr!=0.
REQ-021 Read path: combinational, with write-through bypass.
- When wb_en=1 and wb_addr==rsN!=0 in the same cycle, rsN data = wb_data.
REQ-022 Latency: one cycle; outputs update at the posedge following acceptance.
- An instruction is accepted when in_valid=1, stall=0 and flush=0.
REQ-023 Immediate by opcode, all sign-extended from bit 31:
- I-type (0010011, 0000011, 1100111): inst[31:20].
- S-type (0100011): {inst[31:25], inst[11:7]}.
- B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U-type (0110111, 0010111): {inst[31:12], 12'b0}.
- J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- R-type (0110011) and illegal opcodes: 0.
REQ-024 reg_write = 1 for R, I-ALU, load, LUI, AUIPC, JAL and JALR opcodes with rd!=0; 0 for store and branch.
REQ-025 illegal = 1 for any opcode outside the nine listed; out_valid stays 1, reg_write=0, imm=0.
REQ-026 Priority: flush over stall over normal update.
REQ-027 flush=1: next posedge loads a bubble.
- Bubble: out_valid=0, out_instr=NOP_INSTR, reg_write=0, illegal=0, all other outputs 0.
REQ-028 stall=1, flush=0: all ID/EX outputs hold; register-file writes still occur.
REQ-029 in_valid=0 with no stall and no flush: next posedge loads a bubble.
REQ-030 Stalled operands: values captured at acceptance are not refreshed by later writebacks while stalled.

Reset
REQ-031 While reset is asserted, all 32 registers are cleared asynchronously.
REQ-032 While reset is asserted, the ID/EX outputs hold the bubble value, out_instr=NOP_INSTR.
REQ-033 Reset overrides stall, flush and wb_en.
- A write in the same cycle as reset is discarded.
- Deasserting reset mid-operation resumes with the bubble outputs.

Verification
REQ-034 Write and read: wb x5=32'hDEADBEEF; then 0x00528313 (addi x6,x5,5) -> rs1_data=DEADBEEF, imm=5, rd=6, reg_write=1.
REQ-035 Bypass and x0: wb_en=1, wb_addr=1, wb_data=32'h1234 in the same cycle as add x3,x1,x0 -> rs1_data=0x1234, rs2_data=0; writing x0=0xFFFF, then reading x0 -> 0.
REQ-036 Immediates: sw x2,-4(x1) (0xFE20AE23) -> imm=FFFFFFFC; beq x0,x0,-8 (0xFE000CE3) -> imm=FFFFFFF8; lui x1,0x12345 -> imm=12345000; jal x1,2048 -> imm=00000800.
REQ-037 Stall and flush: stall for 3 cycles -> outputs unchanged; flush and stall together -> bubble, out_valid=0.
REQ-038 Illegal opcode: 0x0000007F -> illegal=1, reg_write=0, out_valid=1.
REQ-039 Reset: assert reset mid-stream after writes -> outputs become the bubble at once; afterwards every register reads 0.

Source files
------------

// File: rtl/instruction_decode_unit.sv
// Instruction decode stage: 32x32 register file with write-through bypass,
// RV32I field/immediate decode, and the ID/EX pipeline register with
// stall, flush and bubble handling.
module instruction_decode_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instruction_Code,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        illegal
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        reg_write;
    logic        illegal;
  } idex_t;

  // Bubble: not valid, NOP encoding, every other field zero.
  localparam idex_t BUBBLE = idex_t'({1'b0, NOP_INSTR, 130'd0});

  logic [31:0] regs [32];
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [6:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_dec;
  logic        legal_dec, writes_rd;
  idex_t       decoded;
  idex_t       idex_reg, idex_next;

  assign op      = Instruction_Code[6:0];
  assign rd_idx  = Instruction_Code[11:7];
  assign rs1_idx = Instruction_Code[19:15];
  assign rs2_idx = Instruction_Code[24:20];

  // Register file: cleared asynchronously by reset; x0 is never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Operand read: x0 is hardwired zero, same-cycle writeback is forwarded.
  always_comb begin
    rs1_val = regs[rs1_idx];
    rs2_val = regs[rs2_idx];
    if (rs1_idx == 5'd0)                        rs1_val = '0;
    else if (wb_en && (wb_addr == rs1_idx))     rs1_val = wb_data;
    if (rs2_idx == 5'd0)                        rs2_val = '0;
    else if (wb_en && (wb_addr == rs2_idx))     rs2_val = wb_data;
  end

  // Immediate format, legality and rd-write class selected by opcode.
  always_comb begin
    imm_dec   = '0;
    legal_dec = 1'b1;
    writes_rd = 1'b0;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_dec   = {{20{Instruction_Code[31]}}, Instruction_Code[31:20]};
        writes_rd = 1'b1;
      end
      OP_STORE: begin
        imm_dec = {{20{Instruction_Code[31]}}, Instruction_Code[31:25],
                   Instruction_Code[11:7]};
      end
      OP_BRANCH: begin
        imm_dec = {{19{Instruction_Code[31]}}, Instruction_Code[31],
                   Instruction_Code[7], Instruction_Code[30:25],
                   Instruction_Code[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm_dec   = {Instruction_Code[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm_dec   = {{11{Instruction_Code[31]}}, Instruction_Code[31],
                     Instruction_Code[19:12], Instruction_Code[20],
                     Instruction_Code[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OP_REG: begin
        writes_rd = 1'b1;
      end
      default: begin
        legal_dec = 1'b0;
      end
    endcase
  end

  // Assemble the would-be ID/EX contents for the incoming instruction.
  always_comb begin
    decoded           = BUBBLE;
    decoded.valid     = 1'b1;
    decoded.instr     = Instruction_Code;
    decoded.opcode    = op;
    decoded.funct3    = Instruction_Code[14:12];
    decoded.funct7    = Instruction_Code[31:25];
    decoded.rd        = rd_idx;
    decoded.rs1       = rs1_idx;
    decoded.rs2       = rs2_idx;
    decoded.rs1_data  = rs1_val;
    decoded.rs2_data  = rs2_val;
    decoded.imm       = imm_dec;
    decoded.reg_write = writes_rd && (rd_idx != 5'd0);
    decoded.illegal   = !legal_dec;
  end

  // Pipeline control: flush beats stall, stall holds, otherwise load or bubble.
  always_comb begin
    idex_next = idex_reg;
    if (flush)         idex_next = BUBBLE;
    else if (stall)    idex_next = idex_reg;
    else if (in_valid) idex_next = decoded;
    else               idex_next = BUBBLE;
  end

  // ID/EX register; reset forces the bubble immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) idex_reg <= BUBBLE;
    else       idex_reg <= idex_next;
  end

  assign out_valid = idex_reg.valid;
  assign out_instr = idex_reg.instr;
  assign opcode    = idex_reg.opcode;
  assign funct3    = idex_reg.funct3;
  assign funct7    = idex_reg.funct7;
  assign rd        = idex_reg.rd;
  assign rs1       = idex_reg.rs1;
  assign rs2       = idex_reg.rs2;
  assign rs1_data  = idex_reg.rs1_data;
  assign rs2_data  = idex_reg.rs2_data;
  assign imm       = idex_reg.imm;
  assign reg_write = idex_reg.reg_write;
  assign illegal   = idex_reg.illegal;

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Self-checking bench for instruction_decode_unit: directed vector table,
// hand-written stall/flush/reset sequences, and randomized traffic checked
// against a behavioural model of the register file and ID/EX register.
module tb_instruction_decode_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instruction_Code = '0;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0, wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid, reg_write, illegal;
  logic [31:0] out_instr, rs1_data, rs2_data, imm;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_decode_unit #(.NOP_INSTR(NOP)) dut (
    .clock(clock), .reset(reset), .Instruction_Code(Instruction_Code),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_instr(out_instr), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        reg_write, illegal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rd;
    logic        reg_write, illegal;
  } vec_t;

  logic [31:0] mregs [32];
  logic [6:0]  legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  vec_t        vecs [10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.valid = 0; e.instr = NOP; e.opcode = 0; e.funct3 = 0; e.funct7 = 0;
    e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.rs1_data = 0; e.rs2_data = 0; e.imm = 0;
    e.reg_write = 0; e.illegal = 0;
    return e;
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Immediate value computed as the encoded field value minus the sign weight.
  function automatic logic [31:0] ref_imm(logic [31:0] ins);
    logic [31:0] v;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67:
        v = 32'(ins[31:20]) - (ins[31] ? 32'd4096 : 32'd0);
      7'h23:
        v = 32'(ins[31:25]) * 32 + 32'(ins[11:7]) - (ins[31] ? 32'd4096 : 32'd0);
      7'h63:
        v = 32'(ins[31]) * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32
            + 32'(ins[11:8]) * 2 - (ins[31] ? 32'd8192 : 32'd0);
      7'h37, 7'h17:
        v = ins - 32'(ins[11:0]);
      7'h6F:
        v = 32'(ins[31]) * 32'd1048576 + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048
            + 32'(ins[30:21]) * 2 - (ins[31] ? 32'd2097152 : 32'd0);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_read(logic [4:0] r);
    if (r == 0) return 0;
    if (wb_en && wb_addr == r) return wb_data;
    return mregs[r];
  endfunction

  function automatic exp_t ref_next(exp_t cur);
    exp_t e;
    logic [31:0] ins;
    bit writer;
    ins = Instruction_Code;
    if (flush) return bubble();
    if (stall) return cur;
    if (!in_valid) return bubble();
    e.valid = 1; e.instr = ins; e.opcode = ins[6:0]; e.funct3 = ins[14:12];
    e.funct7 = ins[31:25]; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.rs1_data = ref_read(e.rs1);
    e.rs2_data = ref_read(e.rs2);
    e.imm = ref_imm(ins);
    e.illegal = !is_legal(e.opcode);
    writer = is_legal(e.opcode) && e.opcode != 7'h23 && e.opcode != 7'h63;
    e.reg_write = writer && e.rd != 0;
    return e;
  endfunction

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.valid));
    chk({tag, ".out_instr"}, out_instr, e.instr);
    chk({tag, ".opcode"}, 32'(opcode), 32'(e.opcode));
    chk({tag, ".funct3"}, 32'(funct3), 32'(e.funct3));
    chk({tag, ".funct7"}, 32'(funct7), 32'(e.funct7));
    chk({tag, ".rd"}, 32'(rd), 32'(e.rd));
    chk({tag, ".rs1"}, 32'(rs1), 32'(e.rs1));
    chk({tag, ".rs2"}, 32'(rs2), 32'(e.rs2));
    chk({tag, ".rs1_data"}, rs1_data, e.rs1_data);
    chk({tag, ".rs2_data"}, rs2_data, e.rs2_data);
    chk({tag, ".imm"}, imm, e.imm);
    chk({tag, ".reg_write"}, 32'(reg_write), 32'(e.reg_write));
    chk({tag, ".illegal"}, 32'(illegal), 32'(e.illegal));
  endtask

  task automatic accept(input logic [31:0] ins);
    Instruction_Code = ins; in_valid = 1; stall = 0; flush = 0;
    tick();
  endtask

  initial begin
    exp_t cur;
    //               instr         wb  addr  data          rs1          rs2          imm          rd rw il
    vecs[0] = '{32'h00000013, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0,       32'h0,       32'h0,       5'd0,  1'b0, 1'b0};
    vecs[1] = '{32'h00528313, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h5,     5'd6,  1'b1, 1'b0};
    vecs[2] = '{32'h000081B3, 1'b1, 5'd1, 32'h1234,     32'h1234,    32'h0,       32'h0,       5'd3,  1'b1, 1'b0};
    vecs[3] = '{32'h00000033, 1'b1, 5'd0, 32'hFFFF,     32'h0,       32'h0,       32'h0,       5'd0,  1'b0, 1'b0};
    vecs[4] = '{32'h000001B3, 1'b0, 5'd0, 32'h0,        32'h0,       32'h0,       32'h0,       5'd3,  1'b1, 1'b0};
    vecs[5] = '{32'hFE20AE23, 1'b0, 5'd0, 32'h0,        32'h1234,    32'h0,       32'hFFFFFFFC, 5'd28, 1'b0, 1'b0};
    vecs[6] = '{32'hFE000CE3, 1'b0, 5'd0, 32'h0,        32'h0,       32'h0,       32'hFFFFFFF8, 5'd25, 1'b0, 1'b0};
    vecs[7] = '{32'h123450B7, 1'b0, 5'd0, 32'h0,        32'h0,       32'h0,       32'h12345000, 5'd1,  1'b1, 1'b0};
    vecs[8] = '{32'h001000EF, 1'b0, 5'd0, 32'h0,        32'h0,       32'h1234,    32'h00000800, 5'd1,  1'b1, 1'b0};
    vecs[9] = '{32'h0000007F, 1'b0, 5'd0, 32'h0,        32'h0,       32'h0,       32'h0,       5'd0,  1'b0, 1'b1};

    // Reset state.
    #2 reset = 1;
    #1 chk_all("reset", bubble());
    tick(); tick();
    reset = 0;
    #1 chk_all("after_reset", bubble());

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      accept(vecs[i].instr);
      wb_en = 0;
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d.out_instr", i), out_instr, vecs[i].instr);
      chk($sformatf("vec%0d.rs1_data", i), rs1_data, vecs[i].rs1_data);
      chk($sformatf("vec%0d.rs2_data", i), rs2_data, vecs[i].rs2_data);
      chk($sformatf("vec%0d.imm", i), imm, vecs[i].imm);
      chk($sformatf("vec%0d.rd", i), 32'(rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d.reg_write", i), 32'(reg_write), 32'(vecs[i].reg_write));
      chk($sformatf("vec%0d.illegal", i), 32'(illegal), 32'(vecs[i].illegal));
    end

    // Stall for three cycles while writebacks hit the captured operand.
    accept(32'h00528313);
    for (int k = 0; k < 3; k++) begin
      Instruction_Code = 32'h001000EF; in_valid = 1; stall = 1;
      wb_en = 1; wb_addr = 5; wb_data = 32'hA0 + 32'(k);
      tick();
      chk($sformatf("stall%0d.out_instr", k), out_instr, 32'h00528313);
      chk($sformatf("stall%0d.rs1_data", k), rs1_data, 32'hDEADBEEF);
      chk($sformatf("stall%0d.imm", k), imm, 32'h5);
      chk($sformatf("stall%0d.out_valid", k), 32'(out_valid), 32'd1);
    end
    wb_en = 0;
    accept(32'h00528313);
    chk("post_stall.rs1_data", rs1_data, 32'hA2);

    // Flush together with stall yields a bubble.
    flush = 1; stall = 1; in_valid = 1;
    tick();
    flush = 0; stall = 0;
    chk("flush_stall.out_valid", 32'(out_valid), 32'd0);
    chk("flush_stall.out_instr", out_instr, NOP);
    chk("flush_stall.rd", 32'(rd), 32'd0);
    chk("flush_stall.rs1_data", rs1_data, 32'd0);

    // No valid input loads a bubble.
    accept(32'h123450B7);
    in_valid = 0;
    tick();
    chk_all("idle", bubble());

    // Asynchronous reset mid-stream; a write alongside reset is lost.
    wb_en = 1; wb_addr = 7; wb_data = 32'h77;
    accept(32'h00528313);
    stall = 1; wb_addr = 9; wb_data = 32'h99;
    #2 reset = 1;
    #1 chk_all("mid_reset", bubble());
    tick();
    reset = 0; wb_en = 0; stall = 0;
    for (int r = 0; r < 32; r++) begin
      accept((32'(r) << 20) | (32'(r) << 15) | 32'h33);
      chk($sformatf("cleared_x%0d.rs1_data", r), rs1_data, 32'd0);
      chk($sformatf("cleared_x%0d.rs2_data", r), rs2_data, 32'd0);
    end

    // Randomized traffic against the reference model.
    in_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    foreach (mregs[r]) mregs[r] = 0;
    cur = bubble();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom();
      if ($urandom_range(0, 9) != 0) ins[6:0] = legal_ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) != 0) ins[19:15] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) != 0) ins[24:20] = 5'($urandom_range(0, 7));
      Instruction_Code = ins;
      in_valid = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      wb_en    = $urandom_range(0, 1) != 0;
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom();
      cur = ref_next(cur);
      if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
      tick();
      chk_all($sformatf("rnd%0d", n), cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
